// File: rtl/spi_host_bridge.sv
// Wishbone-slave SPI mode-0 master: turns one 32-bit bus access into a single
// command/address/data frame for the wb_spi_slave bridge and acks on completion.
module spi_host_bridge #(
   parameter int CLK_DIV    = 2,
   parameter int DUMMY_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [25:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_dat,
   output logic        sck,
   output logic        ssn,
   output logic        mosi,
   input  logic        miso,
   output logic        busy
);

   localparam int CW = $clog2(2*CLK_DIV+1);
   localparam logic [CW-1:0] HALF_LAST     = CW'(CLK_DIV-1);
   localparam logic [CW-1:0] FULL_LAST     = CW'(2*CLK_DIV-1);
   localparam logic [6:0]    WR_BITS       = 7'd72;
   localparam logic [6:0]    RD_BITS       = 7'(72+DUMMY_BITS);
   localparam logic [6:0]    RD_DATA_START = 7'(40+DUMMY_BITS);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [6:0]     bit_q, bit_d;
   logic [71:0]    tx_q, tx_d;
   logic [31:0]    rx_q, rx_d;
   logic           we_q, we_d;
   logic           sck_q, sck_d, ssn_q, ssn_d, mosi_q, mosi_d;
   logic           ack_q, ack_d, busy_q, busy_d;
   logic [31:0]    rdat_q, rdat_d;
   logic [6:0]     frame_len;

   assign frame_len = we_q ? WR_BITS : RD_BITS;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      we_d    = we_q;
      rdat_d  = rdat_q;
      ack_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_wb_cyc && i_wb_stb) begin
               state_d = S_SETUP;
               cnt_d   = '0;
               bit_d   = '0;
               we_d    = i_wb_we;
               tx_d    = {(i_wb_we ? 8'h02 : 8'h03), 6'b0, i_wb_adr,
                          (i_wb_we ? i_wb_dat : 32'h0)};
            end
         end
         S_SETUP: begin
            if (cnt_q == HALF_LAST) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            // Last cycle of the high phase: sample MISO, then SCK falls and MOSI advances.
            if (cnt_q == HALF_LAST) begin
               tx_d = {tx_q[70:0], 1'b0};
               if (!we_q && bit_q >= RD_DATA_START) rx_d = {rx_q[30:0], miso};
            end
            if (cnt_q == FULL_LAST) begin
               cnt_d = '0;
               bit_d = bit_q + 7'd1;
               if (bit_q + 7'd1 == frame_len) state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt_q == HALF_LAST) begin
               state_d = S_GAP;
               cnt_d   = '0;
               ack_d   = i_wb_cyc;
               if (!we_q) rdat_d = rx_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == FULL_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      sck_d  = (state_d == S_SHIFT) && (cnt_d <= HALF_LAST);
      ssn_d  = !(state_d inside {S_SETUP, S_SHIFT, S_HOLD});
      mosi_d = !ssn_d && tx_d[71];
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sck_q   <= 1'b0;
         ssn_q   <= 1'b1;
         mosi_q  <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sck_q   <= sck_d;
         ssn_q   <= ssn_d;
         mosi_q  <= mosi_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         rdat_q  <= rdat_d;
      end
   end

   // Frame payload registers carry no reset; they are reloaded on every acceptance.
   always_ff @(posedge clk) begin
      tx_q <= tx_d;
      rx_q <= rx_d;
      we_q <= we_d;
   end

   assign sck      = sck_q;
   assign ssn      = ssn_q;
   assign mosi     = mosi_q;
   assign o_wb_ack = ack_q;
   assign busy     = busy_q;
   assign o_wb_dat = rdat_q;

endmodule

// File: tb/tb_spi_host_bridge.sv
// Self-checking bench for spi_host_bridge: two instances (CLK_DIV=2 and 1),
// SPI slave behaviour and expected frames/latencies computed from the frame rules.
module tb_spi_host_bridge;

   localparam int DUMMY = 8;

   typedef struct {
      int          rises;
      logic [127:0] bits;
      int          acks;
      int          t_busy;
      int          t_ack;
      int          t_first_rise;
      int          t_last_fall;
      int          high_cycles;
      int          mosi_bad;
      bit          timeout;
      logic        ssn_r, sck_r, mosi_r, ack_r, busy_r;
      logic [31:0] dat;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        cyc2 = 0, stb2 = 0, we2 = 0, miso2 = 0;
   logic [25:0] adr2 = '0;
   logic [31:0] wdat2 = '0;
   logic        ack2, sck2, ssn2, mosi2, busy2;
   logic [31:0] dat2;

   logic        cyc1 = 0, stb1 = 0, we1 = 0, miso1 = 0;
   logic [25:0] adr1 = '0;
   logic [31:0] wdat1 = '0;
   logic        ack1, sck1, ssn1, mosi1, busy1;
   logic [31:0] dat1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_host_bridge #(.CLK_DIV(2), .DUMMY_BITS(DUMMY)) dut2 (
      .clk(clk), .rst(rst), .i_wb_cyc(cyc2), .i_wb_stb(stb2), .i_wb_we(we2),
      .i_wb_adr(adr2), .i_wb_dat(wdat2), .o_wb_ack(ack2), .o_wb_dat(dat2),
      .sck(sck2), .ssn(ssn2), .mosi(mosi2), .miso(miso2), .busy(busy2));

   spi_host_bridge #(.CLK_DIV(1), .DUMMY_BITS(DUMMY)) dut1 (
      .clk(clk), .rst(rst), .i_wb_cyc(cyc1), .i_wb_stb(stb1), .i_wb_we(we1),
      .i_wb_adr(adr1), .i_wb_dat(wdat1), .o_wb_ack(ack1), .o_wb_dat(dat1),
      .sck(sck1), .ssn(ssn1), .mosi(mosi1), .miso(miso1), .busy(busy1));

   // Reference: frame bit count and ack latency measured from the first busy cycle.
   function automatic int frame_bits(input bit we);
      return we ? 72 : 72 + DUMMY;
   endfunction

   function automatic int ack_delta(input int cd, input bit we);
      return 2*cd + 2*frame_bits(we)*cd;
   endfunction

   task automatic set_req(input bit fast, input logic c, input logic s, input logic w,
                          input logic [25:0] a, input logic [31:0] d);
      if (fast) begin
         cyc1 = c; stb1 = s; we1 = w; adr1 = a; wdat1 = d;
      end else begin
         cyc2 = c; stb2 = s; we2 = w; adr2 = a; wdat2 = d;
      end
   endtask

   task automatic run_frame(input bit fast, input bit we, input logic [25:0] adr,
                            input logic [31:0] wdat, input logic [31:0] sdat,
                            input int drop_cyc_at, input int rst_at, output obs_t o);
      int   t = 0;
      int   idx;
      int   dstart = 40 + DUMMY;
      bit   prev_sck = 0, seen_busy = 0, done = 0;
      logic s_sck, s_ssn, s_mosi, s_ack, s_busy, v;
      o = '{default: 0};
      o.bits = '0;
      set_req(fast, 1'b1, 1'b1, we, adr, wdat);
      while (!done) begin
         @(posedge clk); #1;
         t++;
         if (t > 3000) begin
            o.timeout = 1;
            break;
         end
         if (fast) begin
            s_sck = sck1; s_ssn = ssn1; s_mosi = mosi1; s_ack = ack1; s_busy = busy1;
         end else begin
            s_sck = sck2; s_ssn = ssn2; s_mosi = mosi2; s_ack = ack2; s_busy = busy2;
         end
         if (s_busy && !seen_busy) begin
            seen_busy = 1;
            o.t_busy = t;
            set_req(fast, 1'b1, 1'b0, ~we, 26'($urandom), $urandom);
         end
         if (s_ack) begin
            o.acks++;
            o.t_ack = t;
         end
         if (s_ssn && s_mosi) o.mosi_bad++;
         if (s_sck) o.high_cycles++;
         if (s_sck && !prev_sck) begin
            if (o.rises == 0) o.t_first_rise = t;
            o.bits = {o.bits[126:0], s_mosi};
            o.rises++;
            if (drop_cyc_at != 0 && o.rises == drop_cyc_at)
               set_req(fast, 1'b0, 1'b0, 1'b0, '0, '0);
            if (rst_at != 0 && o.rises == rst_at) begin
               rst = 1'b1;
               @(posedge clk); #1;
               if (fast) begin
                  o.ssn_r = ssn1; o.sck_r = sck1; o.mosi_r = mosi1; o.ack_r = ack1; o.busy_r = busy1;
               end else begin
                  o.ssn_r = ssn2; o.sck_r = sck2; o.mosi_r = mosi2; o.ack_r = ack2; o.busy_r = busy2;
               end
               rst = 1'b0;
               break;
            end
         end
         if (!s_sck && prev_sck) begin
            o.t_last_fall = t;
            idx = o.rises;
            if (!we && idx >= dstart && idx < dstart + 32) v = sdat[31 - (idx - dstart)];
            else v = 1'($urandom);
            if (fast) miso1 = v; else miso2 = v;
         end
         prev_sck = s_sck;
         if (seen_busy && !s_busy) done = 1;
      end
      o.dat = fast ? dat1 : dat2;
      set_req(fast, 1'b0, 1'b0, 1'b0, '0, '0);
      if (fast) miso1 = 1'b0; else miso2 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (ssn2 !== 1'b1) begin n_fail++; $display("FAIL reset_ssn: got %b want 1", ssn2); end
      n_checks++; if (sck2 !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", sck2); end
      n_checks++; if (mosi2 !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi2); end
      n_checks++; if (ack2 !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack2); end
      n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy2); end
      n_checks++; if (dat2 !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", dat2); end
      n_checks++; if ({ssn1, sck1, busy1} !== 3'b100) begin n_fail++; $display("FAIL reset_fast: got %b want 100", {ssn1, sck1, busy1}); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic check_write(input string nm, input bit fast, input logic [25:0] a, input logic [31:0] d);
      obs_t o;
      int   cd = fast ? 1 : 2;
      run_frame(fast, 1'b1, a, d, 32'h0, 0, 0, o);
      n_checks++; if (o.timeout) begin n_fail++; $display("FAIL %s_timeout: frame did not finish", nm); end
      n_checks++; if (o.rises !== 72) begin n_fail++; $display("FAIL %s_rises: got %0d want 72", nm, o.rises); end
      n_checks++; if (o.bits[71:0] !== {8'h02, 6'b0, a, d}) begin n_fail++; $display("FAIL %s_mosi: got %h want %h", nm, o.bits[71:0], {8'h02, 6'b0, a, d}); end
      n_checks++; if (o.acks !== 1) begin n_fail++; $display("FAIL %s_ack_count: got %0d want 1", nm, o.acks); end
      n_checks++; if (o.t_ack - o.t_busy !== ack_delta(cd, 1'b1)) begin n_fail++; $display("FAIL %s_ack_time: got N+%0d want N+%0d", nm, o.t_ack - o.t_busy + 1, ack_delta(cd, 1'b1) + 1); end
      n_checks++; if (o.t_first_rise - o.t_busy !== cd) begin n_fail++; $display("FAIL %s_first_rise: got +%0d want +%0d", nm, o.t_first_rise - o.t_busy, cd); end
      n_checks++; if (o.mosi_bad !== 0) begin n_fail++; $display("FAIL %s_mosi_idle: got %0d high cycles want 0", nm, o.mosi_bad); end
      if (fast) begin
         n_checks++; if (o.high_cycles !== 72) begin n_fail++; $display("FAIL %s_sck_high: got %0d want 72", nm, o.high_cycles); end
         n_checks++; if (o.t_last_fall - o.t_first_rise !== 143) begin n_fail++; $display("FAIL %s_sck_span: got %0d want 143", nm, o.t_last_fall - o.t_first_rise); end
      end
   endtask

   task automatic check_read(input string nm, input logic [25:0] a, input logic [31:0] sd, input int drop_at);
      obs_t o;
      int   want_acks = (drop_at != 0) ? 0 : 1;
      run_frame(1'b0, 1'b0, a, 32'h0, sd, drop_at, 0, o);
      n_checks++; if (o.timeout) begin n_fail++; $display("FAIL %s_timeout: frame did not finish", nm); end
      n_checks++; if (o.rises !== 80) begin n_fail++; $display("FAIL %s_rises: got %0d want 80", nm, o.rises); end
      n_checks++; if (o.bits[79:32] !== {8'h03, 6'b0, a, 8'h00}) begin n_fail++; $display("FAIL %s_mosi: got %h want %h", nm, o.bits[79:32], {8'h03, 6'b0, a, 8'h00}); end
      n_checks++; if (o.dat !== sd) begin n_fail++; $display("FAIL %s_data: got %h want %h", nm, o.dat, sd); end
      n_checks++; if (o.acks !== want_acks) begin n_fail++; $display("FAIL %s_ack_count: got %0d want %0d", nm, o.acks, want_acks); end
      if (drop_at == 0) begin
         n_checks++; if (o.t_ack - o.t_busy !== ack_delta(2, 1'b0)) begin n_fail++; $display("FAIL %s_ack_time: got N+%0d want N+%0d", nm, o.t_ack - o.t_busy + 1, ack_delta(2, 1'b0) + 1); end
      end
   endtask

   task automatic test_write();
      check_write("write_fixed", 1'b0, 26'h4, 32'hA5A50F0F);
      for (int i = 0; i < 3; i++) check_write("write_rand", 1'b0, 26'($urandom), $urandom);
   endtask

   task automatic test_read();
      check_read("read_fixed", 26'h10, 32'hDEADBEEF, 0);
      for (int i = 0; i < 3; i++) check_read("read_rand", 26'($urandom), $urandom, 0);
   endtask

   task automatic test_back_to_back();
      logic [25:0]  a1 = 26'($urandom), a2 = 26'($urandom);
      logic [31:0]  d1 = $urandom, d2 = $urandom;
      logic [127:0] b2 = '0;
      int t = 0, acks = 0, t_ack1 = -1, t_ssn2 = -1, r2 = 0;
      bit prev_ssn = 1, prev_sck = 0, done = 0, tmo = 0;
      set_req(1'b0, 1'b1, 1'b1, 1'b1, a1, d1);
      while (!done) begin
         @(posedge clk); #1;
         t++;
         if (t > 3000) begin tmo = 1; break; end
         if (ack2) begin
            acks++;
            if (acks == 1) begin
               t_ack1 = t;
               set_req(1'b0, 1'b1, 1'b1, 1'b1, a2, d2);
            end else begin
               set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            end
         end
         if (acks >= 1 && prev_ssn && !ssn2 && t_ssn2 < 0) t_ssn2 = t;
         if (acks >= 1 && sck2 && !prev_sck) begin
            b2 = {b2[126:0], mosi2};
            r2++;
         end
         if (acks == 2 && !busy2) done = 1;
         prev_ssn = ssn2;
         prev_sck = sck2;
      end
      repeat (20) begin
         @(posedge clk); #1;
         if (ack2) acks++;
      end
      n_checks++; if (tmo) begin n_fail++; $display("FAIL b2b_timeout: two frames did not finish"); end
      n_checks++; if (t_ssn2 - t_ack1 !== 5) begin n_fail++; $display("FAIL b2b_gap: got %0d want 5", t_ssn2 - t_ack1); end
      n_checks++; if (acks !== 2) begin n_fail++; $display("FAIL b2b_acks: got %0d want 2", acks); end
      n_checks++; if (r2 !== 72 || b2[71:0] !== {8'h02, 6'b0, a2, d2}) begin n_fail++; $display("FAIL b2b_frame2: got %0d bits %h want 72 bits %h", r2, b2[71:0], {8'h02, 6'b0, a2, d2}); end
      n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy got %b want 0", busy2); end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      run_frame(1'b0, 1'b1, 26'($urandom), $urandom, 32'h0, 0, 20, o);
      n_checks++; if (o.ssn_r !== 1'b1 || o.sck_r !== 1'b0) begin n_fail++; $display("FAIL rstmid_spi: ssn/sck got %b%b want 10", o.ssn_r, o.sck_r); end
      n_checks++; if (o.mosi_r !== 1'b0 || o.busy_r !== 1'b0) begin n_fail++; $display("FAIL rstmid_mosi_busy: got %b%b want 00", o.mosi_r, o.busy_r); end
      n_checks++; if (o.ack_r !== 1'b0 || o.acks !== 0) begin n_fail++; $display("FAIL rstmid_ack: got %b/%0d want 0/0", o.ack_r, o.acks); end
      n_checks++; if (o.dat !== 32'h0) begin n_fail++; $display("FAIL rstmid_dat: got %h want 0", o.dat); end
      check_read("rstmid_read", 26'($urandom), $urandom, 0);
   endtask

   task automatic test_dropped_cyc_fast();
      check_read("drop_cyc", 26'($urandom), $urandom, 30);
      check_write("fast_write", 1'b1, 26'($urandom), $urandom);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_mid();
      test_dropped_cyc_fast();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
